serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1, request to compute A - B, sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH, minuend, captured when start is accepted.
REQ-006 SHALL have port B, input, WIDTH, subtrahend, captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high in RUN and DONE states.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 SHALL have port diff, output, WIDTH, result A - B modulo 2^WIDTH.
REQ-010 SHALL have port borrow, output, 1, unsigned borrow-out (1 iff A < B unsigned).
REQ-011 SHALL have port ovf, output, 1, signed two's-complement overflow of A - B.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, DONE, held in a registered state variable.
REQ-013 SHALL, in IDLE with start=1 at a clock edge, latch A and B into internal shift registers, clear the internal borrow bit and bit counter to 0, and move to RUN.
REQ-014 SHALL ignore start, A and B in RUN and DONE; no restart, no operand change.
REQ-015 SHALL, in RUN, process one bit per cycle LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br); operand registers shift right; d shifts into the MSB of an internal result register.
REQ-016 SHALL increment the bit counter each RUN cycle and leave RUN after exactly WIDTH RUN cycles (counter = WIDTH-1 on the last bit), entering DONE.
REQ-017 SHALL, on the edge entering DONE, load diff from the completed internal result, borrow from the final borrow bit, and ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]) using the captured operands.
REQ-018 SHALL assert done for exactly the single cycle spent in DONE, then return to IDLE on the next edge.
REQ-019 SHALL give latency: start accepted at edge E0, done high in the cycle after edge E(WIDTH), i.e. E32 for WIDTH=32; busy high from after E0 until after E(WIDTH+1).
REQ-020 SHALL hold diff, borrow, ovf stable from DONE until the next result load; no partial results SHALL appear on diff during RUN.
REQ-021 SHALL accept a new start in the IDLE cycle immediately following DONE; minimum issue interval is WIDTH+2 cycles.
REQ-022 SHALL treat all arithmetic as modulo 2^WIDTH; no saturation.

Reset
REQ-023 SHALL, when rst_n=0 at a clock edge, force state to IDLE, and busy, done, diff, borrow, ovf, counter, borrow bit and shift registers to 0.
REQ-024 SHALL, on reset during RUN or DONE, abort the operation with no done pulse and no result update.
REQ-025 SHALL give reset priority over start at the same edge; start is not accepted.
REQ-026 SHALL not accept start until the first edge with rst_n=1 following reset.

Verification
REQ-027 SHALL cover: A=0, B=0, start -> done at E32; diff=0x00000000, borrow=0, ovf=0.
REQ-028 SHALL cover: A=7, B=4 -> diff=0x00000003, borrow=0, ovf=0.
REQ-029 SHALL cover: A=3, B=5 -> diff=0xFFFFFFFE, borrow=1, ovf=0.
REQ-030 SHALL cover: A=0x80000000, B=1 -> diff=0x7FFFFFFF, borrow=0, ovf=1; and A=0x7FFFFFFF, B=0xFFFFFFFF -> diff=0x80000000, borrow=1, ovf=1.
REQ-031 SHALL cover: start pulsed again with A=1, B=1 at E10 of an A=7, B=4 operation -> ignored; result 0x00000003 at E32; busy high throughout.
REQ-032 SHALL cover: rst_n=0 at E15 of an operation -> busy=0, done never pulses, diff=0; next start with A=9, B=2 -> diff=0x00000007 after 32 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, one bit per clock, LSB first.
// Ports:
//   clk    - clock, all state changes on rising edge
//   rst_n  - synchronous active-low reset
//   start  - request a subtraction, only sampled in IDLE
//   A, B   - minuend / subtrahend, captured when start is accepted
//   busy   - high while RUN or DONE
//   done   - single-cycle pulse, result valid
//   diff   - A - B modulo 2^WIDTH, held until the next result
//   borrow - unsigned borrow out (A < B)
//   ovf    - signed two's-complement overflow of A - B
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d, ovf_q, ovf_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             bit_d, bit_br;
    logic [WIDTH-1:0] res_next;
    assign bit_d    = a_q[0] ^ b_q[0] ^ br_q;
    assign bit_br   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign res_next = {bit_d, res_q[WIDTH-1:1]};
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = A;
                b_d     = B;
                a_msb_d = A[WIDTH-1];
                b_msb_d = B[WIDTH-1];
                br_d    = 1'b0;
                cnt_d   = '0;
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_next;
                br_d  = bit_br;
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish the full result in the same edge that enters DONE
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    diff_d   = res_next;
                    borrow_d = bit_br;
                    ovf_d    = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven + scoreboard bench for serial_subtractor (WIDTH=32).
module tb_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, borrow, ovf;
    logic [31:0] diff;

    serial_subtractor #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        br;
        logic        ov;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        br;
        logic        ov;
    } vec_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [31:0] last_diff = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.d  = a - b;
        e.br = (a < b);
        e.ov = (a[31] != b[31]) && (e.d[31] != a[31]);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending result
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", diff, e.d);
                chk("borrow", {31'd0, borrow}, {31'd0, e.br});
                chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
                last_diff = e.d;
            end
        end
    end

    // Starts an operation at the current negedge. glitch_at/rst_at give the
    // edge index (after E0) just before which a restart or reset is driven.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input exp_t e,
                          input int glitch_at, input int rst_at);
        int  n;
        bit  stable, busy_ok;
        start = 1'b1;
        A = a;
        B = b;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        n = 0;
        stable = 1'b1;
        busy_ok = 1'b1;
        while (!done && n <= 40) begin
            if (diff !== last_diff) stable = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (n == glitch_at) begin
                start = 1'b1;
                A = 32'd1;
                B = 32'd1;
            end else start = 1'b0;
            if (n == rst_at) begin
                rst_n = 1'b0;
                void'(sb.pop_back());
                @(negedge clk);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_diff", diff, 32'd0);
                last_diff = '0;
                rst_n = 1'b1;
                begin
                    int dc;
                    dc = done_cnt;
                    repeat (40) @(negedge clk);
                    chk("abort_no_done", done_cnt, dc);
                end
                return;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", n, 32);
        chk("stable_in_run", {31'd0, stable}, 32'd1);
        chk("busy_in_run", {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0003, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", diff, 32'd0);
        chk("rst_borrow", {31'd0, borrow}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);

        // Reset wins over a simultaneous start
        start = 1'b1;
        A = 32'd5;
        B = 32'd1;
        @(negedge clk);
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_prio_idle", {31'd0, busy}, 32'd0);

        // Back-to-back table vectors: each starts in the first IDLE cycle after DONE
        for (int i = 0; i < 7; i++)
            run_op(tbl[i].a, tbl[i].b, '{tbl[i].d, tbl[i].br, tbl[i].ov}, -1, -1);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i == 0) ? a : $urandom;
            run_op(a, b, model(a, b), -1, -1);
        end

        // Restart attempt at E10 is ignored
        run_op(32'd7, 32'd4, '{32'h0000_0003, 1'b0, 1'b0}, 9, -1);

        // Reset at E15 aborts, then a fresh op completes
        run_op(32'd7, 32'd4, '{32'h0000_0003, 1'b0, 1'b0}, -1, 14);
        run_op(32'd9, 32'd2, '{32'h0000_0007, 1'b0, 1'b0}, -1, -1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
